// File: rtl/universal_shift_register.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// with a modulo-WIDTH shift counter and a one-cycle pulse on every counter wrap.
module universal_shift_register #(
  parameter int               WIDTH       = 8,
  parameter int               COUNT_WIDTH = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                   clock_pos,
  input  logic                   reset_neg,
  input  logic [1:0]             mode_select,
  input  logic                   serial_in_msb,
  input  logic                   serial_in_lsb,
  input  logic [WIDTH-1:0]       parallel_in,
  output logic [WIDTH-1:0]       parallel_out,
  output logic                   serial_out_lsb,
  output logic                   serial_out_msb,
  output logic [COUNT_WIDTH-1:0] shift_count,
  output logic                   shift_done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

  logic [WIDTH-1:0]       data_q, data_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   done_q, done_d;
  logic                   shift_en;
  logic                   count_wrap;

  // Both shift directions share one counter; direction changes never clear it.
  assign shift_en   = (mode_select == MODE_RIGHT) || (mode_select == MODE_LEFT);
  assign count_wrap = (count_q == COUNT_LAST);

  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (mode_select)
      MODE_HOLD:  data_d = data_q;
      MODE_RIGHT: data_d = {serial_in_msb, data_q[WIDTH-1:1]};
      MODE_LEFT:  data_d = {data_q[WIDTH-2:0], serial_in_lsb};
      MODE_LOAD: begin
        data_d  = parallel_in;
        count_d = '0;
      end
      default:    data_d = data_q;
    endcase
    if (shift_en) begin
      count_d = count_wrap ? '0 : count_q + COUNT_ONE;
      done_d  = count_wrap;
    end
  end

  always_ff @(posedge clock_pos or negedge reset_neg) begin
    if (!reset_neg) begin
      data_q  <= RESET_VALUE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign parallel_out   = data_q;
  assign serial_out_lsb = data_q[0];
  assign serial_out_msb = data_q[WIDTH-1];
  assign shift_count    = count_q;
  assign shift_done     = done_q;

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits (>= 2).
REQ-002 The block SHALL have parameter COUNT_WIDTH, default 3, shift counter width (2**COUNT_WIDTH >= WIDTH).
REQ-003 The block SHALL have parameter RESET_VALUE, default 0 (WIDTH bits), register contents after reset.
REQ-004 The block SHALL have port clock_pos  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_neg  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port mode_select  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 The block SHALL have port serial_in_msb  input  1  bit entering at bit WIDTH-1 on shift right.
REQ-008 The block SHALL have port serial_in_lsb  input  1  bit entering at bit 0 on shift left.
REQ-009 The block SHALL have port parallel_in  input  WIDTH  data captured on parallel load.
REQ-010 The block SHALL have port parallel_out  output  WIDTH  current register contents, registered.
REQ-011 The block SHALL have port serial_out_lsb  output  1  equal to parallel_out[0].
REQ-012 The block SHALL have port serial_out_msb  output  1  equal to parallel_out[WIDTH-1].
REQ-013 The block SHALL have port shift_count  output  COUNT_WIDTH  number of shifts since the last load, modulo WIDTH.
REQ-014 The block SHALL have port shift_done  output  1  one-cycle registered pulse after every WIDTH-th shift.

Function
REQ-015 The block SHALL, for mode 00, hold the register contents and shift_count unchanged and drive shift_done 0 on the next cycle.
REQ-016 The block SHALL, for mode 01, load register <= {serial_in_msb, register[WIDTH-1:1]} on each rising edge.
REQ-017 The block SHALL, for mode 10, load register <= {register[WIDTH-2:0], serial_in_lsb} on each rising edge.
REQ-018 The block SHALL, for mode 11, load register <= parallel_in, clear shift_count to 0 and drive shift_done 0 on the next cycle.
REQ-019 The block SHALL produce zero latency from the clock edge to the output: parallel_out, serial_out_* and shift_count reflect the edge that updated them, with no added delay.
REQ-020 The block SHALL, on every shift edge (mode 01 or 10), increment shift_count; when shift_count equals WIDTH-1, the next value SHALL be 0.
REQ-021 The block SHALL set shift_done to 1 for exactly one cycle after the edge on which shift_count wraps from WIDTH-1 to 0, and to 0 otherwise.
REQ-022 The block SHALL count mixed directions as shifts: alternating 01 and 10 across cycles SHALL still increment shift_count and SHALL NOT clear it.
REQ-023 The block SHALL assert shift_done again exactly WIDTH shifts after a wrap during continuous shifting, with no dead cycle.
REQ-024 The block SHALL leave shift_count unchanged across hold cycles interleaved with shifts; shifts before and after the hold accumulate.
REQ-025 The block SHALL treat serial inputs and parallel_in as don't-care in modes where they are not used.

Reset
REQ-026 The block SHALL, while reset_neg=0, immediately and asynchronously force parallel_out=RESET_VALUE, shift_count=0 and shift_done=0, independent of clock_pos.
REQ-027 The block SHALL abandon any in-progress shift sequence when reset_neg is asserted mid-operation; counting SHALL restart from 0.
REQ-028 The block SHALL act on mode_select at the first rising edge after reset_neg deasserts.

Verification
REQ-029 The bench SHALL check reset: with WIDTH=8, RESET_VALUE=8'h00, register loaded with 8'hFF, assert reset_neg=0 between edges -> parallel_out=8'h00, shift_count=0 and shift_done=0 immediately, without a clock edge.
REQ-030 The bench SHALL check load and shift right: load 8'hA5, then one shift right with serial_in_msb=1 -> parallel_out=8'hD2, serial_out_lsb=0, shift_count=1.
REQ-031 The bench SHALL check load and shift left: load 8'h81, then one shift left with serial_in_lsb=0 -> parallel_out=8'h02, serial_out_msb=0.
REQ-032 The bench SHALL check the wrap pulse: load, then 8 consecutive shift-right edges -> shift_count returns to 0 and shift_done=1 for one cycle only; 8 more shifts -> second pulse with no gap.
REQ-033 The bench SHALL check hold and load interaction: 5 shifts, 3 hold cycles, 3 shifts -> shift_done after the 8th shift; separately, 5 shifts then load -> shift_count=0 and no pulse.
REQ-034 The bench SHALL check reset mid-sequence: 6 shifts, assert reset_neg, release, 8 shifts -> shift_done only after the 8th post-reset shift.
